vx_smem_responder: RTL and testbench



---
 rtl/vx_smem_responder.sv | 154 +++++++++++++++
 tb/tb_vx_smem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_smem_responder.sv
// Shared-memory scratchpad responder for the per-lane dcache request interface.
// Accepts one same-tag batch of lane requests and serves the lanes one per cycle from a single-port word memory.
module vx_smem_responder #(
    parameter int NUM_REQS   = 4,
    parameter int WORD_SIZE  = 4,
    parameter int SIZE       = 16384,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS-1:0]               req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]   req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic                              rsp_valid,
    output logic [NUM_REQS-1:0]               rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    input  logic                              rsp_ready
);

    localparam int WORDS  = SIZE / WORD_SIZE;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int DATA_W = WORD_SIZE * 8;
    localparam int LANE_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RSP    = 2'd2;

    logic [1:0]           state_reg;
    logic [NUM_REQS-1:0]  pend_mask_reg;
    logic [NUM_REQS-1:0]  pend_mask_next;
    logic [NUM_REQS-1:0]  rw_reg;
    logic                 has_load_reg;
    logic [TAG_WIDTH-1:0] tag_reg;
    logic [NUM_REQS-1:0]  tmask_reg;

    logic [IDX_W-1:0]     idx_reg    [NUM_REQS];
    logic [WORD_SIZE-1:0] byteen_reg [NUM_REQS];
    logic [DATA_W-1:0]    wdata_reg  [NUM_REQS];
    logic [DATA_W-1:0]    rdata_reg  [NUM_REQS];

    logic [TAG_WIDTH-1:0] lane_tag    [NUM_REQS];
    logic [IDX_W-1:0]     lane_idx    [NUM_REQS];
    logic [WORD_SIZE-1:0] lane_byteen [NUM_REQS];
    logic [DATA_W-1:0]    lane_data   [NUM_REQS];
    logic [NUM_REQS-1:0]  tag_hit;
    logic [NUM_REQS-1:0]  unused_addr_hi;

    logic [LANE_W-1:0]    leader;
    logic [LANE_W-1:0]    sel;
    logic                 fire;
    logic                 mem_we;

    logic [WORD_SIZE-1:0][7:0] mem [WORDS];

    // Unpack the flat lane buses; only the low index bits of an address select a word.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane
        assign lane_tag[gi]    = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
        assign lane_idx[gi]    = req_addr[gi*ADDR_WIDTH +: IDX_W];
        assign lane_byteen[gi] = req_byteen[gi*WORD_SIZE +: WORD_SIZE];
        assign lane_data[gi]   = req_data[gi*DATA_W +: DATA_W];
        assign unused_addr_hi[gi] = ^req_addr[gi*ADDR_WIDTH+IDX_W +: ADDR_WIDTH-IDX_W];
        assign tag_hit[gi]     = req_valid[gi] && (lane_tag[gi] == lane_tag[leader]);
        assign rsp_data[gi*DATA_W +: DATA_W] = rdata_reg[gi];
    end

    // Descending scans so the lowest set lane is the one left standing.
    always_comb begin
        leader = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (req_valid[i]) leader = LANE_W'(i);
        end
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (pend_mask_reg[i]) sel = LANE_W'(i);
        end
    end

    assign pend_mask_next = pend_mask_reg & (pend_mask_reg - 1'b1);

    // Gated by reset_n so acceptance drops the moment reset is applied.
    assign req_ready = (reset_n && state_reg == S_IDLE) ? tag_hit : '0;
    assign fire      = |req_ready;
    assign mem_we    = (state_reg == S_ACCESS) && rw_reg[sel];

    assign rsp_valid = (state_reg == S_RSP);
    assign rsp_tmask = tmask_reg;
    assign rsp_tag   = tag_reg;

    // Batch operands are only meaningful under pend_mask, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fire) begin
            rw_reg <= req_rw;
            for (int i = 0; i < NUM_REQS; i++) begin
                idx_reg[i]    <= lane_idx[i];
                byteen_reg[i] <= lane_byteen[i];
                wdata_reg[i]  <= lane_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < WORD_SIZE; b++) begin
                if (byteen_reg[sel][b]) mem[idx_reg[sel]][b] <= wdata_reg[sel][b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            pend_mask_reg <= '0;
            has_load_reg  <= 1'b0;
            tag_reg       <= '0;
            tmask_reg     <= '0;
            for (int i = 0; i < NUM_REQS; i++) rdata_reg[i] <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (fire) begin
                        pend_mask_reg <= req_ready;
                        has_load_reg  <= |(req_ready & ~req_rw);
                        tag_reg       <= lane_tag[leader];
                        tmask_reg     <= '0;
                        state_reg     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    pend_mask_reg <= pend_mask_next;
                    if (!rw_reg[sel]) begin
                        rdata_reg[sel] <= mem[idx_reg[sel]];
                        tmask_reg[sel] <= 1'b1;
                    end
                    if (pend_mask_next == '0) state_reg <= has_load_reg ? S_RSP : S_IDLE;
                end
                S_RSP: begin
                    if (rsp_ready) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_smem_responder.sv
// Directed and randomized batches for vx_smem_responder, checked against a lane-ordered memory model.
module tb_vx_smem_responder;

    localparam int N     = 4;
    localparam int AW    = 30;
    localparam int TW    = 16;
    localparam int DW    = 32;
    localparam int WORDS = 4096;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    t_valid = '0;
    logic [N-1:0]    t_rw = '0;
    logic [AW-1:0]   t_addr [N];
    logic [3:0]      t_be   [N];
    logic [DW-1:0]   t_data [N];
    logic [TW-1:0]   t_tag  [N];
    logic            rsp_ready = 1'b0;

    logic [N*AW-1:0] req_addr;
    logic [N*4-1:0]  req_byteen;
    logic [N*DW-1:0] req_data;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [N-1:0]    rsp_tmask;
    logic [N*DW-1:0] rsp_data;
    logic [TW-1:0]   rsp_tag;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW]  = t_addr[gi];
        assign req_byteen[gi*4 +: 4]  = t_be[gi];
        assign req_data[gi*DW +: DW]  = t_data[gi];
        assign req_tag[gi*TW +: TW]   = t_tag[gi];
    end

    vx_smem_responder #(
        .NUM_REQS(N), .WORD_SIZE(4), .SIZE(16384), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(t_valid), .req_rw(t_rw), .req_addr(req_addr), .req_byteen(req_byteen),
        .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
    );

    int tests = 0;
    int fails = 0;
    int unsigned cyc_cnt = 0;
    int unsigned idle_at = 0;
    logic [DW-1:0] mm [WORDS];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic rw, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [DW-1:0] d, input logic [TW-1:0] tg);
        t_valid[i] = 1'b1;
        t_rw[i]    = rw;
        t_addr[i]  = a;
        t_be[i]    = be;
        t_data[i]  = d;
        t_tag[i]   = tg;
    endtask

    // Present whatever is on t_*, wait for acceptance, then follow the batch to its end.
    task automatic run_batch(input string nm, input int hold);
        logic [N-1:0]    acc;
        logic [N-1:0]    loads;
        logic [DW-1:0]   expd [N];
        logic [TW-1:0]   ltag;
        logic [N*DW-1:0] snap_data;
        int lead, k, idx;
        int unsigned t0, f, r, want;
        bit ok;
        lead = -1;
        for (int i = 0; i < N; i++) if (t_valid[i] && lead < 0) lead = i;
        acc = '0;
        for (int i = 0; i < N; i++) if (t_valid[i] && t_tag[i] == t_tag[lead]) acc[i] = 1'b1;
        ltag = t_tag[lead];
        #1;
        t0 = cyc_cnt;
        ok = 1'b1;
        while (req_ready == '0 && cyc_cnt < t0 + 200) begin
            if (rsp_valid !== 1'b0) ok = 1'b0;
            @(posedge clk); #2;
        end
        want = (t0 > idle_at) ? t0 : idle_at;
        chk({nm, " req_ready"}, req_ready, acc);
        chk({nm, " accept_cycle"}, cyc_cnt, want);
        chk({nm, " no_rsp_while_idle"}, ok, 1'b1);
        f = cyc_cnt;
        loads = '0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            expd[i] = '0;
            if (acc[i]) begin
                k++;
                idx = int'(t_addr[i] % WORDS);
                if (t_rw[i]) begin
                    for (int b = 0; b < 4; b++) if (t_be[i][b]) mm[idx][b*8 +: 8] = t_data[i][b*8 +: 8];
                end else begin
                    expd[i] = mm[idx];
                    loads[i] = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        t_valid = t_valid & ~acc;
        #1;
        if (loads == '0) begin
            idle_at = f + k + 1;
            $display("[TB] %s: store-only batch mask=%h accepted at cycle %0d", nm, acc, f);
            return;
        end
        ok = 1'b1;
        while (rsp_valid !== 1'b1 && cyc_cnt < f + 200) begin
            if (req_ready !== '0) ok = 1'b0;
            @(posedge clk); #2;
        end
        chk({nm, " latency"}, cyc_cnt - f, k + 1);
        chk({nm, " ready_low_in_access"}, ok, 1'b1);
        chk({nm, " rsp_tmask"}, rsp_tmask, loads);
        chk({nm, " rsp_tag"}, rsp_tag, ltag);
        for (int i = 0; i < N; i++) if (loads[i]) chk({nm, " rsp_data"}, rsp_data[i*DW +: DW], expd[i]);
        snap_data = rsp_data;
        ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            if (rsp_valid !== 1'b1 || rsp_data !== snap_data || rsp_tmask !== loads ||
                rsp_tag !== ltag || req_ready !== '0) ok = 1'b0;
        end
        if (hold > 0) chk({nm, " hold_stable"}, ok, 1'b1);
        rsp_ready = 1'b1;
        r = cyc_cnt;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        #1;
        chk({nm, " rsp_dropped"}, rsp_valid, 1'b0);
        idle_at = r + 1;
        $display("[TB] %s: mask=%h loads=%h tag=%h fire=%0d rsp=%0d", nm, acc, loads, ltag, f, r);
    endtask

    initial begin
        bit ok;
        int unsigned t0;
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, '0, 4'h0, '0, 16'h1);

        // Reset state with requests already presented.
        repeat (3) @(posedge clk);
        #2;
        chk("reset req_ready", req_ready, 4'h0);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_tmask", rsp_tmask, 4'h0);
        chk("reset rsp_data", rsp_data, '0);
        chk("reset rsp_tag", rsp_tag, 16'h0);
        t_valid = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_at = cyc_cnt;
        #1;

        // Give every pool word a known value.
        for (int p = 0; p < 16; p += 4) begin
            for (int i = 0; i < N; i++) set_lane(i, 1'b1, AW'(p + i), 4'hF, $urandom, 16'h7);
            run_batch("preload", 0);
        end

        set_lane(0, 1'b1, 30'd5, 4'hF, 32'hDEADBEEF, 16'h1);
        run_batch("t1 store", 0);
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, 30'd5, 4'h0, '0, 16'h12);
        run_batch("t1 load", 0);

        set_lane(0, 1'b1, 30'd7, 4'hF, 32'h11223344, 16'h2);
        run_batch("t2 init", 0);
        set_lane(0, 1'b1, 30'd7, 4'h2, 32'h0000AA00, 16'h9);
        set_lane(2, 1'b0, 30'd7, 4'h0, 32'h0, 16'h9);
        run_batch("t2 mixed", 0);

        for (int i = 0; i < N; i++) set_lane(i, 1'b0, AW'(i + 8), 4'h0, '0, (i < 2) ? 16'h3 : 16'h4);
        run_batch("t3 batch_a", 0);
        run_batch("t3 batch_b", 0);

        set_lane(1, 1'b0, 30'd9, 4'h0, '0, 16'hAB);
        run_batch("t4 hold", 10);
        set_lane(3, 1'b0, 30'd10, 4'h0, '0, 16'hAC);
        run_batch("t4 next", 0);

        set_lane(1, 1'b1, 30'd12, 4'h5, 32'hCAFEF00D, 16'h6);
        set_lane(3, 1'b1, 30'd13, 4'hF, 32'h0BADC0DE, 16'h6);
        run_batch("t5 stores", 0);
        set_lane(0, 1'b0, 30'd12, 4'h0, '0, 16'h6);
        set_lane(2, 1'b0, 30'd13, 4'h0, '0, 16'h6);
        run_batch("t5 after", 0);

        set_lane(0, 1'b1, AW'(WORDS + 2), 4'hF, 32'h5A5A1234, 16'h5);
        run_batch("t6 wrap_store", 0);
        set_lane(1, 1'b0, 30'd2, 4'h0, '0, 16'h5);
        run_batch("t6 wrap_load", 0);

        // Reset while the batch is still being served.
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, AW'(i), 4'h0, '0, 16'h66);
        #1;
        t0 = cyc_cnt;
        while (req_ready == '0 && cyc_cnt < t0 + 50) begin @(posedge clk); #2; end
        chk("t7 req_ready", req_ready, 4'hF);
        @(posedge clk); #1;
        t_valid = 4'h1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("t7 rst rsp_valid", rsp_valid, 1'b0);
        chk("t7 rst req_ready", req_ready, 4'h0);
        chk("t7 rst rsp_tmask", rsp_tmask, 4'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_at = cyc_cnt;
        run_batch("t7 after_reset", 0);
        $display("[TB] t7: reset applied mid-access");

        // Random batches, leftover lanes served before new ones are drawn.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++)
                set_lane(i, 1'($urandom % 2), AW'(($urandom % 16) + WORDS * ($urandom % 3)),
                         4'($urandom), $urandom, 16'h40 + 16'($urandom % 2));
            t_valid = 4'($urandom_range(1, 15));
            ok = 1'b1;
            while (t_valid != '0) run_batch("rand", int'($urandom % 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
